// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing controller.
// Provides frame geometry helpers (HTOTAL/VTOTAL/HSTART/VSTART), the
// controller state enum and the built-in colour-bar palette.
// Optional feature macro used by the controller: VGA_TEST_PATTERN_EN.
package vga_pkg;

    // Controller state: waiting for the FIFO to fill, or scanning frames.
    typedef enum logic {
        WAIT_FILL = 1'b0,
        RUN       = 1'b1
    } state_t;

    localparam int unsigned NUM_BARS = 8;

    // Bar colours left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [23:0] BAR_COLORS [NUM_BARS] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    // Total pixels (or lines) in one period including porches and sync.
    function automatic int unsigned calc_total(
        input int unsigned disp,
        input int unsigned fp,
        input int unsigned pulse,
        input int unsigned bp
    );
        return disp + fp + pulse + bp;
    endfunction

    // First active position: blanking precedes the visible region.
    function automatic int unsigned calc_start(
        input int unsigned fp,
        input int unsigned pulse,
        input int unsigned bp
    );
        return fp + pulse + bp;
    endfunction

    // Offset into the active region where colour bar idx begins.
    function automatic int unsigned bar_bound(
        input int unsigned disp,
        input int unsigned idx
    );
        return (idx * disp) / NUM_BARS;
    endfunction

endpackage

// File: rtl/vga_sync_2ff.sv
// Two-flop synchroniser for a single level signal crossing into clk.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears both stages
//   d   - asynchronous input level
//   q   - synchronised level, two clk cycles of latency
module vga_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability filter: first stage may resolve late, second stage is clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Pixel-domain video timing controller.
// Generates HS/VS/BLANK from configurable timings, pops pixels from a
// first-word-fall-through FIFO during active video, substitutes a fixed
// colour on underflow and counts underflows. Scanning starts only after
// the FIFO reports filled and stops only on a frame boundary when en is low.
// Optional macro VGA_TEST_PATTERN_EN adds an 8-bar colour pattern selected
// per frame by pattern_sel; without it pattern_sel is ignored.
// Ports:
//   pixel_clk, pixel_rst - pixel clock, async active-high reset
//   en                   - display enable, sampled at frame end
//   fifo_ready           - FIFO filled indication (foreign domain)
//   rdata, rempty        - FIFO head word and empty flag
//   read                 - FIFO pop (combinational)
//   pattern_sel          - test pattern request
//   HS, VS, BLANK, RGB   - registered video outputs (BLANK=1 is active)
//   frame_start          - one-cycle pulse after the first pixel of a frame
//   underflow            - sticky underflow flag
//   underflow_cnt        - saturating underflow count
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned      HDISP           = 800,
    parameter int unsigned      VDISP           = 480,
    parameter int unsigned      HFP             = 40,
    parameter int unsigned      HPULSE          = 48,
    parameter int unsigned      HBP             = 40,
    parameter int unsigned      VFP             = 13,
    parameter int unsigned      VPULSE          = 3,
    parameter int unsigned      VBP             = 29,
    parameter bit               HS_POL          = 1'b0,
    parameter bit               VS_POL          = 1'b0,
    parameter int unsigned      RGB_W           = 24,
    parameter logic [RGB_W-1:0] UNDERFLOW_COLOR = RGB_W'(24'hFF00FF)
) (
    input  logic             pixel_clk,
    input  logic             pixel_rst,
    input  logic             en,
    input  logic             fifo_ready,
    input  logic [RGB_W-1:0] rdata,
    input  logic             rempty,
    output logic             read,
    input  logic             pattern_sel,
    output logic             HS,
    output logic             VS,
    output logic             BLANK,
    output logic [RGB_W-1:0] RGB,
    output logic             frame_start,
    output logic             underflow,
    output logic [15:0]      underflow_cnt
);

    localparam int unsigned HTOTAL = calc_total(HDISP, HFP, HPULSE, HBP);
    localparam int unsigned VTOTAL = calc_total(VDISP, VFP, VPULSE, VBP);
    localparam int unsigned HSTART = calc_start(HFP, HPULSE, HBP);
    localparam int unsigned VSTART = calc_start(VFP, VPULSE, VBP);
    localparam int unsigned HW     = $clog2(HTOTAL);
    localparam int unsigned VW     = $clog2(VTOTAL);
    localparam int unsigned CNT_W  = 16;

    localparam logic [HW-1:0]    H_LAST   = HW'(HTOTAL - 1);
    localparam logic [HW-1:0]    H_SYNC_S = HW'(HFP);
    localparam logic [HW-1:0]    H_SYNC_E = HW'(HFP + HPULSE);
    localparam logic [HW-1:0]    H_ACT_S  = HW'(HSTART);
    localparam logic [VW-1:0]    V_LAST   = VW'(VTOTAL - 1);
    localparam logic [VW-1:0]    V_SYNC_S = VW'(VFP);
    localparam logic [VW-1:0]    V_SYNC_E = VW'(VFP + VPULSE);
    localparam logic [VW-1:0]    V_ACT_S  = VW'(VSTART);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    state_t           state_nx;
    logic [HW-1:0]    h;
    logic [HW-1:0]    h_nx;
    logic [VW-1:0]    v;
    logic [VW-1:0]    v_nx;
    logic             ready_sync;
    logic             pattern_active;
    logic [RGB_W-1:0] bar_rgb;

    logic             in_hs;
    logic             in_vs;
    logic             active;
    logic             frame_last;
    logic             underflow_c;

    logic             hs_d;
    logic             vs_d;
    logic             blank_d;
    logic [RGB_W-1:0] rgb_d;
    logic             fs_d;
    logic             uf_d;
    logic [CNT_W-1:0] cnt_d;

    // fifo_ready comes from the write clock domain.
    vga_sync_2ff u_ready_sync (
        .clk (pixel_clk),
        .rst (pixel_rst),
        .d   (fifo_ready),
        .q   (ready_sync)
    );

    // Position decode of the current counter state.
    assign in_hs      = (h >= H_SYNC_S) && (h < H_SYNC_E);
    assign in_vs      = (v >= V_SYNC_S) && (v < V_SYNC_E);
    assign active     = (h >= H_ACT_S) && (v >= V_ACT_S);
    assign frame_last = (h == H_LAST) && (v == V_LAST);

    // State register.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state <= WAIT_FILL;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: en is only honoured at the last pixel of a frame.
    always_comb begin
        state_nx = state;
        case (state)
            WAIT_FILL: if (ready_sync && en) state_nx = RUN;
            RUN:       if (frame_last && !en) state_nx = WAIT_FILL;
            default:   state_nx = WAIT_FILL;
        endcase
    end

    // Raster counters: held at origin while waiting, free-running otherwise.
    always_comb begin
        h_nx = '0;
        v_nx = '0;
        if (state == RUN) begin
            if (h == H_LAST) begin
                h_nx = '0;
                v_nx = (v == V_LAST) ? '0 : v + VW'(1);
            end else begin
                h_nx = h + HW'(1);
                v_nx = v;
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= h_nx;
            v <= v_nx;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [HW-1:0] h_off;
    logic [2:0]    bar_idx;

    // Pattern selection is frozen for the whole frame at its first pixel.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            pattern_active <= 1'b0;
        end else if ((state == RUN) && (h == '0) && (v == '0)) begin
            pattern_active <= pattern_sel;
        end
    end

    // Bar index by comparing against constant boundaries; the last one passed wins.
    assign h_off = h - H_ACT_S;

    always_comb begin
        bar_idx = '0;
        for (int unsigned i = 1; i < NUM_BARS; i++) begin
            if (h_off >= HW'(bar_bound(HDISP, i))) begin
                bar_idx = 3'(i);
            end
        end
    end

    assign bar_rgb = RGB_W'(BAR_COLORS[bar_idx]);
`else
    logic unused_pattern_sel;

    assign unused_pattern_sel = pattern_sel;
    assign pattern_active     = 1'b0;
    assign bar_rgb            = '0;
`endif

    // Output decode: FIFO pop, underflow detection and next register values.
    always_comb begin
        read        = 1'b0;
        underflow_c = 1'b0;
        hs_d        = ~HS_POL;
        vs_d        = ~VS_POL;
        blank_d     = 1'b0;
        rgb_d       = '0;
        fs_d        = 1'b0;
        uf_d        = underflow;
        cnt_d       = underflow_cnt;
        if (state == RUN) begin
            if (in_hs) hs_d = HS_POL;
            if (in_vs) vs_d = VS_POL;
            fs_d = (h == '0) && (v == '0);
            if (active) begin
                blank_d = 1'b1;
                if (pattern_active) begin
                    rgb_d = bar_rgb;
                end else if (rempty) begin
                    underflow_c = 1'b1;
                    rgb_d       = UNDERFLOW_COLOR;
                end else begin
                    read  = 1'b1;
                    rgb_d = rdata;
                end
            end
        end
        if (underflow_c) begin
            uf_d = 1'b1;
            if (underflow_cnt != CNT_MAX) cnt_d = underflow_cnt + CNT_W'(1);
        end
    end

    // Output registers: one cycle behind the counter state.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            HS            <= ~HS_POL;
            VS            <= ~VS_POL;
            BLANK         <= 1'b0;
            RGB           <= '0;
            frame_start   <= 1'b0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            HS            <= hs_d;
            VS            <= vs_d;
            BLANK         <= blank_d;
            RGB           <= rgb_d;
            frame_start   <= fs_d;
            underflow     <= uf_d;
            underflow_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl using the small 14x7 raster.
// A behavioural model tracks the frame position as one integer and derives
// every expected output by arithmetic; a second large instance checks
// counter saturation. Honours VGA_TEST_PATTERN_EN when defined.
module tb_vga_timing_ctrl;

    localparam int T_HD = 8;
    localparam int T_VD = 4;
    localparam int T_HFP = 2;
    localparam int T_HPU = 2;
    localparam int T_HBP = 2;
    localparam int T_VFP = 1;
    localparam int T_VPU = 1;
    localparam int T_VBP = 1;
    localparam int HT  = T_HD + T_HFP + T_HPU + T_HBP;
    localparam int VT  = T_VD + T_VFP + T_VPU + T_VBP;
    localparam int HST = T_HFP + T_HPU + T_HBP;
    localparam int VST = T_VFP + T_VPU + T_VBP;
    localparam int FRAME = HT * VT;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst;
    logic        en;
    logic        fifo_ready;
    logic        pattern_sel;
    logic        force_empty;
    logic [23:0] rdata;
    logic        rempty;
    logic        read;
    logic        HS;
    logic        VS;
    logic        BLANK;
    logic [23:0] RGB;
    logic        frame_start;
    logic        underflow;
    logic [15:0] underflow_cnt;

    int checks = 0;
    int failures = 0;

    // FIFO stand-in: a refill sets a base word and count; pops walk through it.
    int          pops = 0;
    int          fill_mark = 0;
    int          fill_count = 0;
    logic [23:0] head_base = 24'h0;
    int          avail;

    assign avail  = fill_count - (pops - fill_mark);
    assign rdata  = head_base + 24'(pops - fill_mark);
    assign rempty = force_empty || (avail <= 0);

    always #5 pixel_clk = ~pixel_clk;

    always @(posedge pixel_clk) begin
        if (read && !rempty) pops <= pops + 1;
    end

    vga_timing_ctrl #(
        .HDISP(T_HD), .VDISP(T_VD), .HFP(T_HFP), .HPULSE(T_HPU), .HBP(T_HBP),
        .VFP(T_VFP), .VPULSE(T_VPU), .VBP(T_VBP), .HS_POL(1'b0), .VS_POL(1'b0),
        .RGB_W(24), .UNDERFLOW_COLOR(24'hFF00FF)
    ) dut (
        .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .en(en), .fifo_ready(fifo_ready),
        .rdata(rdata), .rempty(rempty), .read(read), .pattern_sel(pattern_sel),
        .HS(HS), .VS(VS), .BLANK(BLANK), .RGB(RGB), .frame_start(frame_start),
        .underflow(underflow), .underflow_cnt(underflow_cnt)
    );

    // Large instance, permanently starved, to reach counter saturation.
    logic        big_rst;
    logic        big_read;
    logic        big_hs;
    logic        big_vs;
    logic        big_blank;
    logic [23:0] big_rgb;
    logic        big_fs;
    logic        big_uf;
    logic [15:0] big_cnt;
    int          big_cyc = 0;

    vga_timing_ctrl #(
        .HDISP(253), .VDISP(253), .HFP(1), .HPULSE(1), .HBP(1),
        .VFP(1), .VPULSE(1), .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0),
        .RGB_W(24), .UNDERFLOW_COLOR(24'hFF00FF)
    ) big_dut (
        .pixel_clk(pixel_clk), .pixel_rst(big_rst), .en(1'b1), .fifo_ready(1'b1),
        .rdata(24'h0), .rempty(1'b1), .read(big_read), .pattern_sel(1'b0),
        .HS(big_hs), .VS(big_vs), .BLANK(big_blank), .RGB(big_rgb), .frame_start(big_fs),
        .underflow(big_uf), .underflow_cnt(big_cnt)
    );

    always @(posedge pixel_clk) begin
        if (!big_rst) big_cyc <= big_cyc + 1;
    end

    function automatic logic [23:0] bar_color(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Reference model: m_pos is the pixel index within the frame while running.
    logic        m_run;
    int          m_pos;
    logic        m_s1;
    logic        m_s2;
    logic        m_pat;
    logic        exp_hs;
    logic        exp_vs;
    logic        exp_blank;
    logic [23:0] exp_rgb;
    logic        exp_fs;
    logic        exp_uf;
    logic [15:0] exp_cnt;
    logic        exp_read;
    int          mh;
    int          mv;
    logic        mact;
    logic        muf;

    assign exp_read = m_run && ((m_pos % HT) >= HST) && ((m_pos / HT) >= VST) && !rempty && !m_pat;

    always @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            m_run <= 1'b0; m_pos <= 0; m_s1 <= 1'b0; m_s2 <= 1'b0; m_pat <= 1'b0;
            exp_hs <= 1'b1; exp_vs <= 1'b1; exp_blank <= 1'b0; exp_rgb <= 24'h0;
            exp_fs <= 1'b0; exp_uf <= 1'b0; exp_cnt <= 16'h0;
        end else begin
            mh   = m_pos % HT;
            mv   = m_pos / HT;
            mact = m_run && (mh >= HST) && (mv >= VST);
            muf  = mact && !m_pat && rempty;
            exp_hs    <= !(m_run && mh >= T_HFP && mh < T_HFP + T_HPU);
            exp_vs    <= !(m_run && mv >= T_VFP && mv < T_VFP + T_VPU);
            exp_blank <= mact;
            exp_fs    <= m_run && (m_pos == 0);
            if (!mact)        exp_rgb <= 24'h0;
            else if (m_pat)   exp_rgb <= bar_color((mh - HST) * 8 / T_HD);
            else if (rempty)  exp_rgb <= 24'hFF00FF;
            else              exp_rgb <= rdata;
            if (muf) begin
                exp_uf <= 1'b1;
                if (exp_cnt != 16'hFFFF) exp_cnt <= exp_cnt + 16'd1;
            end
`ifdef VGA_TEST_PATTERN_EN
            if (m_run && m_pos == 0) m_pat <= pattern_sel;
`endif
            if (!m_run) begin
                if (m_s2 && en) begin
                    m_run <= 1'b1;
                    m_pos <= 0;
                end
            end else if (m_pos == FRAME - 1) begin
                m_pos <= 0;
                if (!en) m_run <= 1'b0;
            end else begin
                m_pos <= m_pos + 1;
            end
            m_s1 <= fifo_ready;
            m_s2 <= m_s1;
        end
    end

    task automatic test_reset();
        @(negedge pixel_clk);
        checks++; if (HS !== 1'b1 || VS !== 1'b1) begin failures++; $display("FAIL reset_sync: HS=%b VS=%b want 1 1", HS, VS); end
        checks++; if (BLANK !== 1'b0 || RGB !== 24'h0) begin failures++; $display("FAIL reset_video: BLANK=%b RGB=%h want 0 000000", BLANK, RGB); end
        checks++; if (frame_start !== 1'b0 || underflow !== 1'b0 || underflow_cnt !== 16'h0) begin
            failures++; $display("FAIL reset_flags: fs=%b uf=%b cnt=%h want 0 0 0000", frame_start, underflow, underflow_cnt); end
        pixel_rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge pixel_clk);
            checks++; if (HS !== 1'b1 || VS !== 1'b1 || BLANK !== 1'b0) begin
                failures++; $display("FAIL idle_outputs: HS=%b VS=%b BLANK=%b want 1 1 0", HS, VS, BLANK); end
            checks++; if (read !== 1'b0) begin failures++; $display("FAIL idle_read: read=%b want 0", read); end
        end
    endtask

    task automatic test_frame();
        int n;
        int hs_low;
        int vs_low;
        int blank_line [VT];
        logic [23:0] exp_word;
        fill_mark  = pops;
        fill_count = 1000000;
        head_base  = 24'($urandom);
        exp_word   = head_base;
        fifo_ready = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge pixel_clk);
            n++;
            if (frame_start === 1'b1) break;
        end
        checks++; if (n != 4) begin failures++; $display("FAIL start_latency: cycles=%0d want 4", n); end
        hs_low = 0; vs_low = 0;
        for (int i = 0; i < VT; i++) blank_line[i] = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge pixel_clk);
            checks++; if (HS !== exp_hs || VS !== exp_vs || BLANK !== exp_blank || frame_start !== exp_fs) begin
                failures++; $display("FAIL frame_timing k=%0d: HS=%b VS=%b BLANK=%b fs=%b want %b %b %b %b",
                    k, HS, VS, BLANK, frame_start, exp_hs, exp_vs, exp_blank, exp_fs); end
            checks++; if (read !== exp_read) begin failures++; $display("FAIL frame_read k=%0d: read=%b want %b", k, read, exp_read); end
            if (HS === 1'b0) hs_low++;
            if (VS === 1'b0) vs_low++;
            if (BLANK === 1'b1) begin
                blank_line[k / HT]++;
                checks++; if (RGB !== exp_word) begin failures++; $display("FAIL frame_data k=%0d: RGB=%h want %h", k, RGB, exp_word); end
                exp_word = exp_word + 24'd1;
            end else begin
                checks++; if (RGB !== 24'h0) begin failures++; $display("FAIL frame_blank_rgb k=%0d: RGB=%h want 000000", k, RGB); end
            end
        end
        checks++; if (hs_low != 2 * VT) begin failures++; $display("FAIL hs_width: low=%0d want %0d", hs_low, 2 * VT); end
        checks++; if (vs_low != HT) begin failures++; $display("FAIL vs_width: low=%0d want %0d", vs_low, HT); end
        for (int i = 0; i < VT; i++) begin
            checks++; if (blank_line[i] != ((i >= VST) ? T_HD : 0)) begin
                failures++; $display("FAIL blank_line %0d: count=%0d want %0d", i, blank_line[i], (i >= VST) ? T_HD : 0); end
        end
    endtask

    task automatic test_underflow();
        logic [23:0] word;
        int n;
        n = 0;
        while (n < 200 && !(m_run && m_pos == (VST + 1) * HT + HST + 2)) begin
            @(negedge pixel_clk);
            n++;
        end
        checks++; if (n >= 200) begin failures++; $display("FAIL underflow_wait: timeout=%0d want <200", n); end
        force_empty = 1'b1;
        word = rdata;
        #1;
        checks++; if (read !== 1'b0) begin failures++; $display("FAIL underflow_no_pop: read=%b want 0", read); end
        @(negedge pixel_clk);
        force_empty = 1'b0;
        checks++; if (RGB !== 24'hFF00FF || BLANK !== 1'b1) begin failures++; $display("FAIL underflow_rgb: RGB=%h BLANK=%b want ff00ff 1", RGB, BLANK); end
        checks++; if (underflow !== 1'b1 || underflow_cnt !== 16'd1) begin
            failures++; $display("FAIL underflow_count: uf=%b cnt=%0d want 1 1", underflow, underflow_cnt); end
        @(negedge pixel_clk);
        checks++; if (RGB !== word) begin failures++; $display("FAIL underflow_resume: RGB=%h want %h", RGB, word); end
    endtask

    task automatic test_en_disable();
        int n;
        n = 0;
        while (n < 200 && !(m_run && m_pos == 40)) begin
            @(negedge pixel_clk);
            n++;
        end
        en = 1'b0;
        n = 0;
        while (n < 200) begin
            @(negedge pixel_clk);
            n++;
            checks++; if (HS !== exp_hs || BLANK !== exp_blank || RGB !== exp_rgb || read !== exp_read) begin
                failures++; $display("FAIL drain_frame: HS=%b BLANK=%b RGB=%h read=%b want %b %b %h %b",
                    HS, BLANK, RGB, read, exp_hs, exp_blank, exp_rgb, exp_read); end
            if (!m_run) break;
        end
        checks++; if (n != FRAME - 40) begin failures++; $display("FAIL drain_length: cycles=%0d want %0d", n, FRAME - 40); end
        @(negedge pixel_clk);
        for (int i = 0; i < 50; i++) begin
            @(negedge pixel_clk);
            checks++; if (read !== 1'b0 || frame_start !== 1'b0 || BLANK !== 1'b0 || HS !== 1'b1) begin
                failures++; $display("FAIL disabled_idle: read=%b fs=%b BLANK=%b HS=%b want 0 0 0 1", read, frame_start, BLANK, HS); end
        end
        en = 1'b1;
        n = 0;
        while (n < 10) begin
            @(negedge pixel_clk);
            n++;
            if (frame_start === 1'b1) break;
        end
        checks++; if (n != 2) begin failures++; $display("FAIL restart_latency: cycles=%0d want 2", n); end
    endtask

    task automatic test_pattern();
        int n;
        int reads;
        n = 0;
        while (n < 200 && !(m_run && m_pos == FRAME - 3)) begin
            @(negedge pixel_clk);
            n++;
        end
        pattern_sel = 1'b1;
        n = 0;
        while (n < 10) begin
            @(negedge pixel_clk);
            n++;
            if (frame_start === 1'b1) break;
        end
        pattern_sel = 1'b0;
        reads = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge pixel_clk);
            if (read === 1'b1) reads++;
            checks++; if (RGB !== exp_rgb || read !== exp_read) begin
                failures++; $display("FAIL pattern_model k=%0d: RGB=%h read=%b want %h %b", k, RGB, read, exp_rgb, exp_read); end
`ifdef VGA_TEST_PATTERN_EN
            if (BLANK === 1'b1) begin
                checks++; if (RGB !== bar_color((k % HT) - HST)) begin
                    failures++; $display("FAIL pattern_bar k=%0d: RGB=%h want %h", k, RGB, bar_color((k % HT) - HST)); end
            end
`endif
        end
`ifdef VGA_TEST_PATTERN_EN
        checks++; if (reads != 0) begin failures++; $display("FAIL pattern_reads: reads=%0d want 0", reads); end
`else
        checks++; if (reads != T_HD * T_VD) begin failures++; $display("FAIL pattern_ignored_reads: reads=%0d want %0d", reads, T_HD * T_VD); end
`endif
        for (int k = 0; k < FRAME; k++) begin
            @(negedge pixel_clk);
            checks++; if (RGB !== exp_rgb || read !== exp_read) begin
                failures++; $display("FAIL pattern_off k=%0d: RGB=%h read=%b want %h %b", k, RGB, read, exp_rgb, exp_read); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge pixel_clk);
            checks++; if (HS !== exp_hs || VS !== exp_vs || BLANK !== exp_blank || frame_start !== exp_fs) begin
                failures++; $display("FAIL random_sync i=%0d: HS=%b VS=%b BLANK=%b fs=%b want %b %b %b %b",
                    i, HS, VS, BLANK, frame_start, exp_hs, exp_vs, exp_blank, exp_fs); end
            checks++; if (RGB !== exp_rgb || read !== exp_read) begin
                failures++; $display("FAIL random_data i=%0d: RGB=%h read=%b want %h %b", i, RGB, read, exp_rgb, exp_read); end
            checks++; if (underflow !== exp_uf || underflow_cnt !== exp_cnt) begin
                failures++; $display("FAIL random_underflow i=%0d: uf=%b cnt=%0d want %b %0d", i, underflow, underflow_cnt, exp_uf, exp_cnt); end
            if ($urandom_range(0, 199) == 0) en = ~en;
            fifo_ready  = ($urandom_range(0, 9) != 0);
            force_empty = ($urandom_range(0, 7) == 0);
            pattern_sel = 1'($urandom_range(0, 1));
        end
        en = 1'b1; fifo_ready = 1'b1; force_empty = 1'b0; pattern_sel = 1'b0;
    endtask

    task automatic test_reset_midline();
        int n;
        n = 0;
        while (n < 400 && !(m_run && (m_pos % HT) == HST + 3 && (m_pos / HT) >= VST)) begin
            @(negedge pixel_clk);
            n++;
        end
        checks++; if (n >= 400) begin failures++; $display("FAIL midline_wait: timeout=%0d want <400", n); end
        #2;
        pixel_rst = 1'b1;
        #1;
        checks++; if (HS !== 1'b1 || VS !== 1'b1 || BLANK !== 1'b0 || RGB !== 24'h0) begin
            failures++; $display("FAIL midline_video: HS=%b VS=%b BLANK=%b RGB=%h want 1 1 0 000000", HS, VS, BLANK, RGB); end
        checks++; if (frame_start !== 1'b0 || underflow !== 1'b0 || underflow_cnt !== 16'h0 || read !== 1'b0) begin
            failures++; $display("FAIL midline_flags: fs=%b uf=%b cnt=%0d read=%b want 0 0 0 0", frame_start, underflow, underflow_cnt, read); end
        @(negedge pixel_clk);
        pixel_rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge pixel_clk);
            checks++; if (HS !== exp_hs || BLANK !== exp_blank || frame_start !== exp_fs || read !== exp_read) begin
                failures++; $display("FAIL after_reset i=%0d: HS=%b BLANK=%b fs=%b read=%b want %b %b %b %b",
                    i, HS, BLANK, frame_start, read, exp_hs, exp_blank, exp_fs, exp_read); end
        end
    endtask

    task automatic test_saturation();
        // One full 256x256 frame holds 253*253 active pixels, all underflowing.
        while (big_cyc < 65600) @(negedge pixel_clk);
        checks++; if (big_cnt !== 16'd64009) begin failures++; $display("FAIL sat_first_frame: cnt=%0d want 64009", big_cnt); end
        while (big_cyc < 72000) @(negedge pixel_clk);
        checks++; if (big_cnt !== 16'hFFFF || big_uf !== 1'b1) begin
            failures++; $display("FAIL sat_reached: cnt=%h uf=%b want ffff 1", big_cnt, big_uf); end
        repeat (300) @(negedge pixel_clk);
        checks++; if (big_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_no_wrap: cnt=%h want ffff", big_cnt); end
    endtask

    initial begin
        pixel_rst   = 1'b1;
        big_rst     = 1'b1;
        en          = 1'b1;
        fifo_ready  = 1'b0;
        pattern_sel = 1'b0;
        force_empty = 1'b0;
        repeat (2) @(negedge pixel_clk);
        big_rst = 1'b0;
        test_reset();
        test_frame();
        test_underflow();
        test_en_disable();
        test_pattern();
        test_random();
        test_reset_midline();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Parametrised pixel-domain video controller. It generates HS, VS and BLANK from fully configurable timing parameters, and pops pixels from the first-word-fall-through async FIFO filled by the SDRAM reader. It adds start gating on FIFO readiness, underflow substitution and counting, enable/disable on frame boundaries, and an optional built-in test pattern. It sits between the async FIFO read port and `video_if`.

## Interface
Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- HFP / HPULSE / HBP, 40 / 48 / 40, horizontal porch and sync widths in pixels (each ≥1)
- VFP / VPULSE / VBP, 13 / 3 / 29, vertical porch and sync widths in lines (each ≥1)
- HS_POL / VS_POL, 0 / 0, active level of HS / VS
- RGB_W, 24, pixel width
- UNDERFLOW_COLOR, 24'hFF00FF, substitute pixel on underflow (RGB_W bits)

Ports:
- pixel_clk  in  1  pixel clock
- pixel_rst  in  1  reset, asynchronous, active-high
- en  in  1  display enable, pixel_clk domain
- fifo_ready  in  1  asynchronous FIFO-filled indication (write domain); synchronised internally
- rdata  in  RGB_W  FIFO head word (FWFT)
- rempty  in  1  FIFO empty
- read  out  1  FIFO pop, combinational
- pattern_sel  in  1  test pattern request (used only with macro)
- HS / VS  out  1  syncs, registered
- BLANK  out  1  1 = active video, registered
- RGB  out  RGB_W  pixel, registered
- frame_start  out  1  one-cycle pulse, registered
- underflow  out  1  sticky underflow flag
- underflow_cnt  out  16  saturating underflow count

## Operation
- HTOTAL = HDISP+HFP+HPULSE+HBP, VTOTAL = VDISP+VFP+VPULSE+VBP. h counts 0..HTOTAL-1, v counts 0..VTOTAL-1. Counter widths are $clog2(HTOTAL) and $clog2(VTOTAL).
- Line layout: h<HFP front porch; HFP≤h<HFP+HPULSE sync; then back porch; h≥HFP+HPULSE+HBP active. Vertical layout is identical in v.
- Active = h active AND v active.
- States:
  - WAIT_FILL: counters held at 0, outputs idle. Transition to RUN when synchronised fifo_ready=1 and en=1.
  - RUN: counters free-run; h wraps at HTOTAL-1 and increments v; v wraps at VTOTAL-1. At the last pixel of a frame, go to WAIT_FILL if en=0, otherwise continue.
- Only the frame-end en check causes WAIT_FILL re-entry. fifo_ready dropping in RUN is ignored.
- read = RUN AND active AND !rempty AND !pattern_active. FIFO is never popped in WAIT_FILL or blanking.
- Underflow: RUN, active, !pattern_active and rempty. That cycle has no pop; RGB takes UNDERFLOW_COLOR. underflow is set; underflow_cnt increments, saturating at 16'hFFFF.
- pattern_active is latched from pattern_sel at h=0, v=0 of each RUN frame.

## Timing
- Every registered output lags its counter state by exactly 1 cycle.
- fifo_ready synchroniser is 2 flops, so RUN starts no earlier than cycle 3 after fifo_ready rises.
- RGB in active cycles:
  - normal: rdata from the cycle read was asserted
  - underflow: UNDERFLOW_COLOR
- RGB in blanking: 0.
- frame_start is high in the cycle after the h=0, v=0 RUN cycle.
- Reset values: HS=!HS_POL, VS=!VS_POL, BLANK=0, RGB=0, frame_start=0, underflow=0, underflow_cnt=0. State=WAIT_FILL, counters 0, synchroniser 0, pattern_active=0.
- Reset mid-frame: everything returns to these values immediately. The FIFO is not flushed by this block.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - pattern_active frames show 8 equal vertical colour bars across HDISP: white, yellow, cyan, green, magenta, red, blue, black.
  - bar index = (h−HSTART)*8/HDISP, computed with a precomputed per-bar boundary compare, no divider.
  - No reads and no underflow counting during these frames.
- Undefined: pattern_sel ignored, pattern_active tied 0, no pattern logic.

## Structure
- Package vga_pkg: HTOTAL/VTOTAL/HSTART/VSTART computation functions, the state enum (WAIT_FILL, RUN), the colour-bar constant array.
- Sub-module vga_sync_2ff: 2-flop synchroniser, async reset, used for fifo_ready.

## Test plan
Small config for all scenarios: HDISP=8, VDISP=4, HFP=HPULSE=HBP=2, VFP=VPULSE=VBP=1, so HTOTAL=14 and VTOTAL=7.
- Reset, fifo_ready=0, en=1 for 100 cycles -> HS=VS=1, BLANK=0, read never asserted.
- fifo_ready=1, FIFO full of incrementing data -> frame_start after sync latency, HS low 2 cycles per line, VS low 14 cycles, BLANK high 8 cycles per line on v=3..6, RGB equals pushed data in order.
- Force rempty=1 on the third active pixel of a line -> RGB=FF00FF for that pixel, no pop, underflow=1, underflow_cnt=1, next pixel shows the unskipped word.
- Deassert en mid-frame -> frame completes, return to WAIT_FILL, no further reads; reassert en -> new frame_start.
- With VGA_TEST_PATTERN_EN and pattern_sel=1 at the frame boundary -> pixels 0..7 show the 8 bar colours, read=0 throughout the frame.
- Assert pixel_rst mid-line -> all outputs take their reset values in the same cycle; underflow_cnt preloaded near 16'hFFFF saturates and does not wrap.
